// File: rtl/stream_dispatch_1to4.sv
// Valid/ready feeder for the 1-to-4 demux: DEPTH-entry FIFO followed by a registered output stage.
// Optional per-channel transfer counters on cnt_ch when DISPATCH_CNT_EN is defined.
module stream_dispatch_1to4 #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         in_data,
  input  logic [1:0]               in_dest,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rr_mode,
  output logic [WIDTH-1:0]         out_data,
  output logic [1:0]               out_sel,
  output logic [3:0]               out_valid,
  input  logic [3:0]               out_ready,
`ifdef DISPATCH_CNT_EN
  output logic [31:0]              cnt_ch,
`endif
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {S_EMPTY, S_HOLD} state_t;

  logic [WIDTH+1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic [1:0]       rr_ptr_q, rr_ptr_d;

  logic             fifo_empty, fifo_full;
  logic             push, pop, xfer;
  logic [1:0]       push_dest;
  logic [WIDTH+1:0] head;

  // The extra MSB on each pointer tells full from empty when the index bits match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign fifo_level = wr_ptr_q - rd_ptr_q;

  assign in_ready  = !fifo_full && !flush;
  assign push      = in_valid && in_ready;
  assign push_dest = rr_mode ? rr_ptr_q : in_dest;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign xfer      = (state_q == S_HOLD) && out_ready[out_sel_q];
  assign pop       = !fifo_empty && !flush && ((state_q == S_EMPTY) || xfer);

  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = (state_q == S_HOLD) ? 4'(1 << out_sel_q) : 4'b0000;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    state_d    = state_q;
    out_data_d = out_data_q;
    out_sel_d  = out_sel_q;
    rr_ptr_d   = rr_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      state_d  = S_EMPTY;
      rr_ptr_d = 2'd0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        if (rr_mode) rr_ptr_d = rr_ptr_q + 2'd1;
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        out_data_d = head[WIDTH-1:0];
        out_sel_d  = head[WIDTH+1:WIDTH];
        state_d    = S_HOLD;
      end else if (xfer) begin
        state_d = S_EMPTY;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      state_q    <= S_EMPTY;
      out_data_q <= '0;
      out_sel_q  <= 2'd0;
      rr_ptr_q   <= 2'd0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      state_q    <= state_d;
      out_data_q <= out_data_d;
      out_sel_q  <= out_sel_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  // Storage is qualified by the pointers, so it needs no reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {push_dest, in_data};
  end

`ifdef DISPATCH_CNT_EN
  logic [7:0] cnt_q [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else if (flush) begin
      for (int i = 0; i < 4; i++) cnt_q[i] <= 8'd0;
    end else if (xfer) begin
      cnt_q[out_sel_q] <= cnt_q[out_sel_q] + 8'd1;
    end
  end

  assign cnt_ch = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`endif

endmodule

// File: tb/tb_stream_dispatch_1to4.sv
// Bench for stream_dispatch_1to4: directed scenarios plus random traffic against a queue-based model.
module tb_stream_dispatch_1to4;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       in_dest = 2'd0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             rr_mode = 1'b0;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_sel;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready = 4'b0000;
  logic [LW-1:0]    fifo_level;
`ifdef DISPATCH_CNT_EN
  logic [31:0]      cnt_ch;
`endif

  stream_dispatch_1to4 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_data(in_data), .in_dest(in_dest), .in_valid(in_valid), .in_ready(in_ready),
    .rr_mode(rr_mode),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
`ifdef DISPATCH_CNT_EN
    .cnt_ch(cnt_ch),
`endif
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: queue of pending {dest,data}, a held-word slot, rr counter, per-channel counts.
  logic [WIDTH+1:0] mq[$];
  int               m_rr;
  bit               m_hv;
  logic [WIDTH-1:0] m_hd;
  logic [1:0]       m_hs;
  int               m_cnt[4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_rr = 0; m_hv = 0; m_hd = '0; m_hs = 2'd0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
  endtask

  task automatic compare_outputs();
    logic [3:0]  ev;
    logic [31:0] ec;
    ev = m_hv ? 4'(1 << m_hs) : 4'b0000;
    chk("out_valid", 32'(out_valid), 32'(ev));
    chk("out_data", 32'(out_data), 32'(m_hd));
    chk("out_sel", 32'(out_sel), 32'(m_hs));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    ec = {m_cnt[3][7:0], m_cnt[2][7:0], m_cnt[1][7:0], m_cnt[0][7:0]};
`ifdef DISPATCH_CNT_EN
    chk("cnt_ch", cnt_ch, ec);
`endif
  endtask

  // One clock: drive inputs, check in_ready, advance the model, check outputs after the edge.
  task automatic cyc(input bit v, input logic [1:0] d, input logic [WIDTH-1:0] dat,
                     input bit rr, input logic [3:0] ordy, input bit fl);
    bit m_rdy, xfer, can_pop;
    logic [WIDTH+1:0] e;
    in_valid = v; in_dest = d; in_data = dat; rr_mode = rr; out_ready = ordy; flush = fl;
    #1;
    m_rdy = (mq.size() < DEPTH) && !fl;
    chk("in_ready", 32'(in_ready), 32'(m_rdy));
    xfer = m_hv && ordy[m_hs];
    if (fl) begin
      mq.delete();
      m_hv = 0; m_rr = 0;
      for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    end else begin
      can_pop = (mq.size() > 0) && (!m_hv || xfer);
      if (xfer) m_cnt[m_hs] = (m_cnt[m_hs] + 1) % 256;
      if (can_pop) begin
        e = mq.pop_front();
        m_hs = e[WIDTH+1:WIDTH];
        m_hd = e[WIDTH-1:0];
        m_hv = 1;
      end else if (xfer) begin
        m_hv = 0;
      end
      if (v && m_rdy) begin
        mq.push_back({(rr ? 2'(m_rr) : d), dat});
        if (rr) m_rr = (m_rr + 1) % 4;
      end
    end
    @(posedge clk); #1;
    compare_outputs();
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    compare_outputs();

    // Single word to channel 2, visible two edges after acceptance.
    cyc(1, 2'd2, 4'hA, 0, 4'b1111, 0);
    cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);
    chk("first_valid", 32'(out_valid), 32'h4);
    cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);
    chk("first_drop", 32'(out_valid), 32'h0);
    cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);

    // Round-robin burst, back-to-back output.
    for (int i = 1; i <= 5; i++) cyc(1, 2'd3, 4'(i), 1, 4'b1111, 0);
    repeat (4) cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);

    // Fill with consumers stalled, then drain.
    for (int i = 0; i < 7; i++) cyc(1, 2'(i), 4'(i + 6), 0, 4'b0000, 0);
    chk("fill_level", 32'(fifo_level), 32'(DEPTH));
    chk("fill_stall", 32'(in_ready), 32'd0);
    repeat (7) cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);

    // Head-of-line blocking on channel 1.
    cyc(1, 2'd1, 4'h7, 0, 4'b1101, 0);
    cyc(1, 2'd3, 4'h8, 0, 4'b1101, 0);
    repeat (3) cyc(0, 2'd0, 4'h0, 0, 4'b1101, 0);
    chk("hol_hold", 32'(out_valid), 32'h2);
    repeat (4) cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);

    // Flush while holding words, with an input word offered at the same time.
    for (int i = 0; i < 4; i++) cyc(1, 2'd0, 4'(i + 1), 1, 4'b0000, 0);
    cyc(1, 2'd2, 4'hF, 0, 4'b1111, 1);
    chk("flush_valid", 32'(out_valid), 32'h0);
    chk("flush_level", 32'(fifo_level), 32'h0);
    cyc(1, 2'd2, 4'h9, 1, 4'b0000, 0);
    cyc(0, 2'd0, 4'h0, 0, 4'b0000, 0);
    chk("flush_rr", 32'(out_sel), 32'h0);
    repeat (2) cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);

    // Per-channel transfer counts, then flush clears them.
    cyc(0, 2'd0, 4'h0, 0, 4'b1111, 1);
    for (int i = 0; i < 3; i++) cyc(1, 2'd0, 4'(i), 0, 4'b1111, 0);
    cyc(1, 2'd3, 4'hC, 0, 4'b1111, 0);
    repeat (4) cyc(0, 2'd0, 4'h0, 0, 4'b1111, 0);
`ifdef DISPATCH_CNT_EN
    chk("cnt_value", cnt_ch, 32'h01000003);
`endif
    cyc(0, 2'd0, 4'h0, 0, 4'b1111, 1);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) != 0, 2'($urandom), 4'($urandom),
          $urandom_range(0, 3) == 0,
          ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom),
          $urandom_range(0, 63) == 0);
    end

    // Asynchronous reset in the middle of traffic.
    for (int i = 0; i < 5; i++) cyc(1, 2'(i), 4'(i + 3), 0, 4'b0000, 0);
    rst_n = 1'b0;
    #2;
    model_reset();
    compare_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 6; i++) cyc(1, 2'(i), 4'(i), 0, 4'b1111, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stream_dispatch_1to4.md
Name: stream_dispatch_1to4

Overview:
- Upstream feeder for the 1-to-4 data-flow demux.
- Accepts a WIDTH-bit word plus a 2-bit destination on a valid/ready stream and buffers it in a DEPTH-entry FIFO.
- Presents one word at a time on registered out_data/out_sel, which drive the demux i/sel directly.
- Raises a one-hot per-channel valid and retires the word when the addressed consumer asserts ready.

Parameters:
- WIDTH, 4, data word width; matches the demux width.
- DEPTH, 4, FIFO entries; power of 2, at least 2.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of the FIFO, output stage and round-robin pointer.
- in_data  input  WIDTH  upstream word.
- in_dest  input  2  destination channel; ignored when rr_mode=1.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word.
- rr_mode  input  1  1 = destination from the internal round-robin pointer.
- out_data  output  WIDTH  held word; connects to demux i.
- out_sel  output  2  held destination; connects to demux sel.
- out_valid  output  4  one-hot valid; bit out_sel set while a word is held.
- out_ready  input  4  per-channel consumer ready.
- fifo_level  output  $clog2(DEPTH)+1  FIFO occupancy; excludes the output stage.

Behaviour:
- Clock and reset: single clock domain, clk. rst_n is asynchronous, active-low.
- Reset values:
  - FIFO empty, fifo_level=0.
  - out_valid=4'b0000, out_data=0, out_sel=0.
  - rr pointer=0.
  - in_ready=1 after reset release.
- Input side:
  - in_ready = !fifo_full && !flush.
  - Push occurs when in_valid && in_ready at the rising edge.
  - Stored destination = rr_mode ? rr_ptr : in_dest.
  - rr_ptr increments on every push made with rr_mode=1 and wraps 3->0.
  - rr_ptr holds its value when rr_mode toggles; only reset and flush clear it.
- No push while full, even if a pop happens in the same cycle (in_ready depends only on full and flush).
- Output stage FSM:
  - EMPTY: out_valid=0. Loads the FIFO head when the FIFO is non-empty, then goes to HOLD.
  - HOLD: out_valid = one-hot(out_sel); out_data and out_sel are stable.
  - Transfer occurs when out_valid[out_sel] && out_ready[out_sel].
  - On transfer with the FIFO non-empty: load the next head and stay in HOLD, giving back-to-back words at 1 word/cycle.
  - On transfer with the FIFO empty: go to EMPTY.
  - out_ready bits other than out_sel are ignored.
- Latency: a word accepted at edge E0 into an empty block gives out_valid high after edge E0+1. There is no bypass path.
- Ordering: strict FIFO order across all channels. A stalled channel blocks all later words (head-of-line blocking is intended).
- fifo_level:
  - Push only: +1.
  - Pop to the output stage only: -1.
  - Push and pop in the same cycle: unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally. Full/empty are determined by an extra wrap bit.
- flush:
  - The next edge empties the FIFO, clears out_valid and sets rr_ptr=0.
  - flush overrides any push or transfer in the same cycle; that word is dropped.
  - out_data and out_sel keep their last values.
- Reset asserted mid-transfer: all state clears immediately and the held word is lost.

Optional Feature:
- Macro: DISPATCH_CNT_EN.
- When defined:
  - Adds output cnt_ch, width 32 = four 8-bit fields, channel 0 in bits [7:0].
  - Each field counts completed transfers on its channel, wraps 255->0.
  - Cleared by rst_n and by flush.
- When undefined: the port and counters are absent. All other behaviour is identical.

Test Plan:
- Reset, then in_valid=1, in_dest=2, in_data=4'hA for 1 cycle -> out_valid=4'b0100, out_data=A, out_sel=2 two cycles after the accept cycle. With out_ready=4'b1111, out_valid returns to 0 the next cycle.
- rr_mode=1: push 5 words 1,2,3,4,5 with out_ready=4'b1111 -> out_sel sequence 0,1,2,3,0. out_valid sequence 0001,0010,0100,1000,0001, with no gap cycles.
- out_ready=0, push words until in_ready=0 -> DEPTH words are accepted in the FIFO (fifo_level=4) plus 1 in the output stage. A 6th push stalls. Then set out_ready=1111 -> all 5 words drain in order, one per cycle.
- Head word for channel 1 with out_ready=4'b1101 -> out_valid stays 0010 and the channel-3 word behind it waits. Setting out_ready[1]=1 releases both in order.
- flush asserted while holding 3 words with in_valid=1 -> next cycle out_valid=0, fifo_level=0, rr_ptr=0, and the concurrent input word is not accepted.
- With DISPATCH_CNT_EN: 3 transfers to channel 0 and 1 to channel 3 -> cnt_ch=32'h01000003. After flush -> 32'h0.
